// File: rtl/switch_debounce4.sv
// Four-channel two-flop synchronizer and debouncer with registered level, rise, fall and change
// outputs. Each channel only accepts a new level after STABLE_CYCLES consecutive differing samples.
module switch_debounce4 #(
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] sw_i,
  output logic [3:0] sw_o,
  output logic [3:0] sw_rise_o,
  output logic [3:0] sw_fall_o,
  output logic       changed_o
);

  typedef enum logic [1:0] {
    StLoStable,
    StPendHi,
    StHiStable,
    StPendLo
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic [3:0]       s1_q, s_q;
  state_e           state_q [4];
  state_e           state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [3:0]       out_q, out_d;
  logic [3:0]       rise_q, rise_d;
  logic [3:0]       fall_q, fall_d;
  logic             changed_q, changed_d;

  always_comb begin
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StLoStable: begin
          if (s_q[i]) begin
            state_d[i] = StPendHi;
            cnt_d[i]   = CNT_W'(1);
          end else begin
            cnt_d[i] = '0;
          end
        end
        StPendHi: begin
          if (!s_q[i]) begin
            // Run broke before acceptance: treat as a glitch.
            state_d[i] = StLoStable;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StHiStable;
            cnt_d[i]   = '0;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        StHiStable: begin
          if (!s_q[i]) begin
            state_d[i] = StPendLo;
            cnt_d[i]   = CNT_W'(1);
          end else begin
            cnt_d[i] = '0;
          end
        end
        StPendLo: begin
          if (s_q[i]) begin
            state_d[i] = StHiStable;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StLoStable;
            cnt_d[i]   = '0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      endcase
    end
    out_d     = (out_q | rise_d) & ~fall_d;
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q      <= '0;
      s_q       <= '0;
      out_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= StLoStable;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q      <= sw_i;
      s_q       <= s1_q;
      out_q     <= out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign sw_o      = out_q;
  assign sw_rise_o = rise_q;
  assign sw_fall_o = fall_q;
  assign changed_o = changed_q;

endmodule

// File: tb/tb_switch_debounce4.sv
// Bench for switch_debounce4: directed vector table plus random stimulus against a
// sliding-window reference model; also checks the downstream NOR output.
module tb_switch_debounce4;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_in = 4'h0;
  logic [3:0] sw_out, sw_rise, sw_fall;
  logic       changed;
  logic       y;

  int n_tests = 0;
  int n_fail  = 0;

  switch_debounce4 #(
    .STABLE_CYCLES(N),
    .CNT_W        (4)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .sw_i     (sw_in),
    .sw_o     (sw_out),
    .sw_rise_o(sw_rise),
    .sw_fall_o(sw_fall),
    .changed_o(changed)
  );

  // Downstream four-input NOR stage fed a..d by sw_out[0..3].
  assign y = ~(sw_out[0] | sw_out[1] | sw_out[2] | sw_out[3]);

  always #5 clk = ~clk;

  // Reference: pins reach the debouncer two edges late; a channel flips once the last N
  // synchronized samples all disagree with its current level.
  bit [3:0] m_p1, m_p2, m_out, m_rise, m_fall;
  bit       m_chg;
  bit [3:0] m_win[$];

  function automatic void model_clear();
    m_p1 = '0; m_p2 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
    m_win = {};
    for (int k = 0; k < int'(N); k++) m_win.push_back(4'h0);
  endfunction

  function automatic void model_edge(input bit rst, input bit [3:0] sw);
    bit [3:0] s, flip;
    if (!rst) begin
      model_clear();
    end else begin
      s    = m_p2;
      m_p2 = m_p1;
      m_p1 = sw;
      m_win.push_back(s);
      if (m_win.size() > int'(N)) void'(m_win.pop_front());
      flip = 4'hF;
      foreach (m_win[k]) flip &= (m_win[k] ^ m_out);
      m_rise = flip & ~m_out;
      m_fall = flip & m_out;
      m_out  = m_out ^ flip;
      m_chg  = |flip;
    end
  endfunction

  task automatic step(input bit rst, input bit [3:0] sw, input string tag);
    @(negedge clk);
    rst_n = rst;
    sw_in = sw;
    @(posedge clk);
    model_edge(rst, sw);
    #1;
    n_tests++;
    if (sw_out !== m_out || sw_rise !== m_rise || sw_fall !== m_fall || changed !== m_chg ||
        y !== ~|m_out) begin
      n_fail++;
      $display("FAIL %s model: got out=%h rise=%h fall=%h chg=%b y=%b, want out=%h rise=%h fall=%h chg=%b y=%b",
               tag, sw_out, sw_rise, sw_fall, changed, y, m_out, m_rise, m_fall, m_chg, ~|m_out);
    end
  endtask

  typedef struct {
    bit       rst;
    bit [3:0] sw;
    int       reps;
    bit [3:0] out;
    bit [3:0] rise;
    bit [3:0] fall;
    bit       chg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit [3:0] s, input int n, input bit [3:0] o,
                              input bit [3:0] ri, input bit [3:0] fa, input bit c);
    vec_t v;
    v.rst = r; v.sw = s; v.reps = n; v.out = o; v.rise = ri; v.fall = fa; v.chg = c;
    vecs.push_back(v);
  endfunction

  initial begin
    model_clear();
    // Reset held with all switches high, then release: accept on 6th edge.
    add(0, 4'hF, 3, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'hF, 5, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'hF, 1, 4'hF, 4'hF, 4'h0, 1);
    add(1, 4'hF, 1, 4'hF, 4'h0, 4'h0, 0);
    add(1, 4'h0, 5, 4'hF, 4'h0, 4'h0, 0);
    add(1, 4'h0, 1, 4'h0, 4'h0, 4'hF, 1);
    // Latency on channel 0, both directions.
    add(1, 4'h1, 5, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h1, 1, 4'h1, 4'h1, 4'h0, 1);
    add(1, 4'h1, 1, 4'h1, 4'h0, 4'h0, 0);
    add(1, 4'h0, 5, 4'h1, 4'h0, 4'h0, 0);
    add(1, 4'h0, 1, 4'h0, 4'h0, 4'h1, 1);
    add(1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0);
    // Short pulse on channel 2 is rejected.
    add(1, 4'h4, 3, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h0, 8, 4'h0, 4'h0, 4'h0, 0);
    // Simultaneous ch0/ch2, then staggered ch1 and ch3.
    add(1, 4'h5, 5, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h5, 1, 4'h5, 4'h5, 4'h0, 1);
    add(1, 4'h5, 1, 4'h5, 4'h0, 4'h0, 0);
    add(1, 4'h7, 2, 4'h5, 4'h0, 4'h0, 0);
    add(1, 4'hF, 3, 4'h5, 4'h0, 4'h0, 0);
    add(1, 4'hF, 1, 4'h7, 4'h2, 4'h0, 1);
    add(1, 4'hF, 1, 4'h7, 4'h0, 4'h0, 0);
    add(1, 4'hF, 1, 4'hF, 4'h8, 4'h0, 1);
    add(1, 4'h0, 5, 4'hF, 4'h0, 4'h0, 0);
    add(1, 4'h0, 1, 4'h0, 4'h0, 4'hF, 1);
    // Reset mid-count on channel 3 restarts the run.
    add(1, 4'h8, 3, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'h8, 1, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h8, 5, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h8, 1, 4'h8, 4'h8, 4'h0, 1);
    // NOR stage: back to y=1, short bounce on d, then accepted high drives y=0.
    add(1, 4'h0, 5, 4'h8, 4'h0, 4'h0, 0);
    add(1, 4'h0, 1, 4'h0, 4'h0, 4'h8, 1);
    add(1, 4'h8, 3, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h0, 6, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h8, 5, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h8, 1, 4'h8, 4'h8, 4'h0, 1);
    // Bounce 1,0,1,1,0 on channel 2 before a steady 1.
    add(1, 4'hC, 1, 4'h8, 4'h0, 4'h0, 0);
    add(1, 4'h8, 1, 4'h8, 4'h0, 4'h0, 0);
    add(1, 4'hC, 2, 4'h8, 4'h0, 4'h0, 0);
    add(1, 4'h8, 1, 4'h8, 4'h0, 4'h0, 0);
    add(1, 4'hC, 5, 4'h8, 4'h0, 4'h0, 0);
    add(1, 4'hC, 1, 4'hC, 4'h4, 4'h0, 1);

    for (int v = 0; v < vecs.size(); v++) begin
      for (int r = 0; r < vecs[v].reps; r++) step(vecs[v].rst, vecs[v].sw, $sformatf("vec%0d", v));
      n_tests++;
      if (sw_out !== vecs[v].out || sw_rise !== vecs[v].rise || sw_fall !== vecs[v].fall ||
          changed !== vecs[v].chg || y !== ~|vecs[v].out) begin
        n_fail++;
        $display("FAIL vec%0d: got out=%h rise=%h fall=%h chg=%b y=%b, want out=%h rise=%h fall=%h chg=%b",
                 v, sw_out, sw_rise, sw_fall, changed, y, vecs[v].out, vecs[v].rise,
                 vecs[v].fall, vecs[v].chg);
      end
    end

    // Random bouncing switches with rare resets; each channel toggles with low probability.
    begin
      bit [3:0] cur = sw_in;
      for (int k = 0; k < 3000; k++) begin
        for (int c = 0; c < 4; c++) if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
        step(($urandom_range(0, 399) != 0), cur, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
